// File: rtl/pclk_rate_ctrl.sv
// pclk_rate_ctrl
//
// Sequences PIPE data-bus-width / PCLK-rate changes for the PHY common
// clocking block. After reset, PhyStatus is held high until the PLL lock
// window expires. After that, width-change requests from the MAC are carried
// out as gated, settled handoffs. Each handoff ends with a one-cycle PhyStatus
// acknowledge.
//
// Configuration macro: PCLK_GATE_EN
//   defined   - PCLK is gated (pclk_gate_n low) around the ratio change.
//   undefined - no GATE state; pclk_gate_n is tied high; a legal request goes
//               straight from IDLE to SWITCH.
//
// Ports:
//   Ref_Clk       in   reference clock; all logic on its rising edge
//   Rst_n         in   synchronous active-low reset
//   width_req     in   request strobe, sampled only in IDLE
//   width_sel     in   requested width (legal: 8, 16, 32)
//   DataBusWidth  out  registered width select to the PCLK divider (reset 8)
//   PhyStatus     out  PIPE PhyStatus (reset 1)
//   busy          out  high in every state except IDLE (reset 1)
//   width_err     out  one-cycle pulse on an illegal request (reset 0)
//   pclk_gate_n   out  active-low PCLK gate (reset 1)

module pclk_rate_ctrl #(
    parameter int LOCK_CYCLES   = 64,
    parameter int GATE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic       Ref_Clk,
    input  logic       Rst_n,
    input  logic       width_req,
    input  logic [5:0] width_sel,
    output logic [5:0] DataBusWidth,
    output logic       PhyStatus,
    output logic       busy,
    output logic       width_err,
    output logic       pclk_gate_n
);

    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam int MAX_WAIT = (LOCK_CYCLES > GATE_CYCLES)
        ? ((LOCK_CYCLES > SETTLE_CYCLES) ? LOCK_CYCLES : SETTLE_CYCLES)
        : ((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES);

    // The counter never wraps; refuse to elaborate if it cannot hold the
    // longest wait.
    generate
        if (MAX_WAIT > (1 << CNT_W)) begin : g_cnt_w_check
            $error("CNT_W too small for the configured wait lengths");
        end
    endgenerate

`ifdef PCLK_GATE_EN
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    typedef enum logic [2:0] {
        PLL_WAIT, IDLE, GATE, SWITCH, SETTLE, ACK
    } state_t;
`else
    typedef enum logic [2:0] {
        PLL_WAIT, IDLE, SWITCH, SETTLE, ACK
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       dbw_q, dbw_d;
    logic [5:0]       tgt_q, tgt_d;
    logic             phy_q, phy_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             gate_n_q, gate_n_d;
    logic             sel_legal;

    assign sel_legal = (width_sel == 6'd8) || (width_sel == 6'd16) ||
                       (width_sel == 6'd32);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        dbw_d    = dbw_q;
        tgt_d    = tgt_q;
        phy_d    = phy_q;
        busy_d   = busy_q;
        err_d    = 1'b0;
        gate_n_d = gate_n_q;
        case (state_q)
            PLL_WAIT: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    phy_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (width_req) begin
                    if (!sel_legal) begin
                        err_d = 1'b1;
                    end else if (width_sel == dbw_q) begin
                        // Nothing to change: acknowledge without gating.
                        state_d = ACK;
                        busy_d  = 1'b1;
                    end else begin
                        tgt_d  = width_sel;
                        busy_d = 1'b1;
`ifdef PCLK_GATE_EN
                        state_d  = GATE;
                        gate_n_d = 1'b0;
`else
                        state_d  = SWITCH;
`endif
                    end
                end
            end
`ifdef PCLK_GATE_EN
            GATE: begin
                if (cnt_q == GATE_LAST) begin
                    state_d = SWITCH;
                    cnt_d   = '0;
                end
            end
`endif
            SWITCH: begin
                dbw_d   = tgt_q;
                state_d = SETTLE;
                cnt_d   = '0;
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ACK;
                    cnt_d   = '0;
`ifdef PCLK_GATE_EN
                    // With gating, PhyStatus rises together with the PCLK
                    // release so the MAC sees a running clock with the ack.
                    phy_d    = 1'b1;
                    gate_n_d = 1'b1;
`endif
                end
            end
            ACK: begin
                cnt_d = '0;
                // ACK raises PhyStatus itself when it was entered with it low,
                // then returns to IDLE after PhyStatus has been high one cycle.
                if (!phy_q) begin
                    phy_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    phy_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = PLL_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Ref_Clk) begin
        if (!Rst_n) begin
            state_q  <= PLL_WAIT;
            cnt_q    <= '0;
            dbw_q    <= 6'd8;
            tgt_q    <= 6'd8;
            phy_q    <= 1'b1;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
            gate_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dbw_q    <= dbw_d;
            tgt_q    <= tgt_d;
            phy_q    <= phy_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            gate_n_q <= gate_n_d;
        end
    end

    assign DataBusWidth = dbw_q;
    assign PhyStatus    = phy_q;
    assign busy         = busy_q;
    assign width_err    = err_q;
`ifdef PCLK_GATE_EN
    assign pclk_gate_n  = gate_n_q;
`else
    assign pclk_gate_n  = 1'b1;
`endif

endmodule

// File: doc/pclk_rate_ctrl.md
# pclk_rate_ctrl

Sequences PIPE data-bus-width and PCLK-rate changes for the PHY common clocking block. After reset it holds PhyStatus high until the PLL settle window expires. It then accepts width-change requests from the MAC. Each request is carried out as a gated, settled handoff: it drives the `DataBusWidth` select that the PCLK divider decodes (8→÷10, 16→÷20, 32→÷40). The block runs on the reference clock, beside the PLL/divider logic.

## Interface
Parameters:
- LOCK_CYCLES, 64 — reference-clock cycles from reset release until the PLL is declared locked
- GATE_CYCLES, 4 — cycles PCLK is gated before the divider ratio changes
- SETTLE_CYCLES, 16 — cycles after the ratio change before the change is acknowledged
- CNT_W, 8 — internal counter width; must hold max(LOCK_CYCLES, GATE_CYCLES, SETTLE_CYCLES)

Ports:
- Ref_Clk  in  1  reference clock (100 MHz); all logic on its rising edge
- Rst_n  in  1  reset, synchronous, active-low
- width_req  in  1  request strobe; sampled only in IDLE
- width_sel  in  6  requested width; legal values 8, 16, 32
- DataBusWidth  out  6  registered width select to the PCLK divider; reset 6'd8
- PhyStatus  out  1  PIPE PhyStatus; reset 1
- busy  out  1  high in every state except IDLE; reset 1
- width_err  out  1  one-cycle pulse on an illegal request; reset 0
- pclk_gate_n  out  1  PCLK enable, active-low gate; reset 1

## Operation
- FSM states: PLL_WAIT, IDLE, GATE, SWITCH, SETTLE, ACK. Reset state is PLL_WAIT with counter = 0.
- PLL_WAIT: the counter increments every cycle. When count == LOCK_CYCLES-1: go to IDLE, PhyStatus←0, busy←0. width_req is ignored in this state and is not queued.
- IDLE, width_req=1, width_sel not in {8,16,32}: width_err←1 for one cycle; stay in IDLE; DataBusWidth unchanged.
- IDLE, width_req=1, width_sel legal and equal to DataBusWidth: go straight to ACK. No gating occurs.
- IDLE, width_req=1, width_sel legal and different: latch width_sel, go to GATE, pclk_gate_n←0, busy←1.
- GATE: hold for GATE_CYCLES cycles, then go to SWITCH.
- SWITCH: one cycle. DataBusWidth←latched width. Go to SETTLE; pclk_gate_n stays 0.
- SETTLE: hold for SETTLE_CYCLES cycles, then go to ACK.
- ACK: one cycle. PhyStatus=1, pclk_gate_n=1. Then go to IDLE, where PhyStatus←0 and busy←0.
- During busy, width_req and width_sel changes are ignored. There is no queueing and no error pulse.
- Reset asserted mid-operation, sampled at an edge: every output returns to its reset value at that edge and the PLL_WAIT window restarts. DataBusWidth returns to 8 even if a switch had already completed.
- The counter is cleared on every state entry. It never wraps, because CNT_W is sized per the parameter rule.

## Timing
- Reset release is the first edge that samples Rst_n=1; call it edge 0. PhyStatus falls at edge LOCK_CYCLES-1 (edge 63 with defaults). The first request is accepted at edge LOCK_CYCLES.
- A request is accepted at edge k:
  - pclk_gate_n is low from edge k.
  - DataBusWidth updates at edge k+GATE_CYCLES+1.
  - PhyStatus is high during cycle k+GATE_CYCLES+SETTLE_CYCLES+1 only.
  - The block is back in IDLE, with busy low, one edge later.
- Defaults: DataBusWidth updates at k+5, PhyStatus pulses at k+21, busy drops at k+22.
- Same-width request at edge k: PhyStatus pulses at k+1, back in IDLE at k+2.
- width_err is registered: it pulses in the cycle after the sampling edge, i.e. it is visible from edge k for exactly one cycle.

## Configuration
- PCLK_GATE_EN defined: behaviour as specified above.
- PCLK_GATE_EN undefined:
  - pclk_gate_n is tied to 1.
  - The GATE state is not compiled.
  - A legal different-width request goes IDLE→SWITCH directly: DataBusWidth updates at k+1, PhyStatus pulses at k+SETTLE_CYCLES+2.
  - All other behaviour is unchanged.

## Test plan
- Reset held 5 cycles then released, width_req=1 throughout → PhyStatus=1 until edge 63, then 0. No width_err. DataBusWidth stays 8 until the first IDLE sample at edge 64.
- In IDLE, request width 16 at edge k → pclk_gate_n=0 from k. DataBusWidth=16 at k+5. PhyStatus pulses at k+21. pclk_gate_n=1 from k+21. busy=0 at k+22. Without PCLK_GATE_EN: DataBusWidth=16 at k+1, PhyStatus pulses at k+18.
- In IDLE, request width 12 → width_err high for exactly one cycle. State, DataBusWidth and PhyStatus are unchanged.
- Request 32 while DataBusWidth=32 → PhyStatus pulses at k+1 and pclk_gate_n never goes low.
- Request 32, then at k+3 pulse width_req with width_sel=8 → the second request is ignored and the final DataBusWidth=32.
- Request 16, then assert Rst_n=0 at k+10 → at that edge DataBusWidth=8, PhyStatus=1, pclk_gate_n=1, busy=1. After release, the PLL_WAIT window restarts with the full 64 cycles.
